// File: rtl/bus_arbiter_mux_if.sv
// Source-to-consumer bus bundle for bus_arbiter_mux: request/data/grant from
// the producers plus the valid/ready output handshake toward the bus consumer.
interface bus_arbiter_mux_if #(
  parameter int N  = 10,
  parameter int W  = 16,
  parameter int SW = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;

  // The arbiter drives grant and the output word.
  modport master (
    input  req, src_data, out_ready,
    output grant, out_valid, out_data, out_src
  );

  // Producers and consumer on the other side of the arbiter.
  modport slave (
    output req, src_data, out_ready,
    input  grant, out_valid, out_data, out_src
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// N-source bus arbiter with a one-word registered output and valid/ready handshake.
// Optional saturating backpressure counter enabled by defining BUS_ARB_STALL_CNT_EN.
module bus_arbiter_mux #(
  parameter int N  = 10,
  parameter int W  = 16,
  parameter int RR = 1,
  parameter int SW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bus_arbiter_mux_if.master  bus
`ifdef BUS_ARB_STALL_CNT_EN
  ,
  output logic [15:0]        stall_count_o
`endif
);

  localparam int NP  = 1 << SW;
  localparam int SWP = SW + 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] src_q, src_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NP-1:0] req_ext;
  logic [SW:0]   scan_idx;
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [W-1:0]  win_data;
  logic [N-1:0]  grant;
  logic          load;

  assign req_ext = NP'(bus.req);

  // Scan N positions starting at rr_ptr (or at 0 for fixed priority); the
  // first set request wins. Sums stay below 2N so one subtraction wraps.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = (RR != 0) ? ({1'b0, rr_ptr_q} + SWP'(k)) : SWP'(k);
      if (scan_idx >= SWP'(N)) scan_idx = scan_idx - SWP'(N);
      if (!win_found && req_ext[scan_idx[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SW-1:0];
      end
    end
  end

  // One-hot decode of the winner and AND-OR data select.
  always_comb begin
    win_oh   = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = win_found && (win_idx == SW'(i));
      if (win_oh[i]) win_data = win_data | bus.src_data[i*W +: W];
    end
  end

  // A word is taken whenever the output slot is empty or drains this cycle.
  assign load  = !rst_i && win_found && ((state_q == ST_EMPTY) || bus.out_ready);
  assign grant = load ? win_oh : '0;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = win_data;
      src_d   = win_idx;
      if (RR != 0) begin
        rr_ptr_d = (win_idx == SW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the output word and source index are reset too, because a held
      // word must be discarded and out_data is observable as zero after reset.
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(grant));
    end
  end

  assign bus.grant     = grant;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef BUS_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles the consumer holds off a valid word; sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_FULL) && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count_o = stall_q;
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: one round-robin and one fixed-priority
// instance, checked against hand-computed expectations.
module tb_bus_arbiter_mux;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_mux_if #(.N(N), .W(W), .SW(SW)) bus_rr ();
  bus_arbiter_mux_if #(.N(N), .W(W), .SW(SW)) bus_fp ();

`ifdef BUS_ARB_STALL_CNT_EN
  logic [15:0] stall_rr;
  logic [15:0] stall_fp;
`endif

  bus_arbiter_mux #(.N(N), .W(W), .RR(1), .SW(SW)) dut_rr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_rr)
`ifdef BUS_ARB_STALL_CNT_EN
    ,
    .stall_count_o (stall_rr)
`endif
  );

  bus_arbiter_mux #(.N(N), .W(W), .RR(0), .SW(SW)) dut_fp (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_fp)
`ifdef BUS_ARB_STALL_CNT_EN
    ,
    .stall_count_o (stall_fp)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] words [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words();
    for (int i = 0; i < N; i++) begin
      bus_rr.src_data[i*W +: W] = words[i];
      bus_fp.src_data[i*W +: W] = words[i];
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_rr.req = 10'h3FF; bus_rr.out_ready = 1'b1;
    bus_fp.req = '0;      bus_fp.out_ready = 1'b1;
    for (int i = 0; i < N; i++) words[i] = 16'(16'hA000 + i);
    load_words();
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++; if (bus_rr.grant !== 10'h000) begin n_err++; $display("FAIL reset_grant: got %h want 000", bus_rr.grant); end
      n_vec++; if (bus_rr.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus_rr.out_valid); end
      n_vec++; if (bus_rr.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", bus_rr.out_data); end
      n_vec++; if (bus_rr.out_src !== 4'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", bus_rr.out_src); end
      n_vec++; if (bus_fp.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_fp_valid: got %b want 0", bus_fp.out_valid); end
`ifdef BUS_ARB_STALL_CNT_EN
      n_vec++; if (stall_rr !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_rr); end
`endif
    end
    rst = 1'b0;
    #1;
    n_vec++; if (bus_rr.grant !== 10'b0000000001) begin n_err++; $display("FAIL first_grant: got %b want 0000000001", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_src !== 4'd0) begin n_err++; $display("FAIL first_src: got %0d want 0", bus_rr.out_src); end
    n_vec++; if (bus_rr.out_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b want 1", bus_rr.out_valid); end
    bus_rr.req = '0;
    tick();
  endtask

  task automatic test_single_source();
    words[2] = 16'hBEEF;
    load_words();
    bus_rr.req = 10'b0000000100;
    bus_rr.out_ready = 1'b1;
    #1;
    n_vec++; if (bus_rr.grant !== 10'b0000000100) begin n_err++; $display("FAIL single_grant: got %b want 0000000100", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus_rr.out_valid); end
    n_vec++; if (bus_rr.out_data !== 16'hBEEF) begin n_err++; $display("FAIL single_data: got %h want beef", bus_rr.out_data); end
    n_vec++; if (bus_rr.out_src !== 4'd2) begin n_err++; $display("FAIL single_src: got %0d want 2", bus_rr.out_src); end
    bus_rr.req = '0;
    #1;
    n_vec++; if (bus_rr.grant !== 10'h000) begin n_err++; $display("FAIL idle_grant: got %b want 0", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", bus_rr.out_valid); end
    n_vec++; if (bus_rr.out_data !== 16'hBEEF) begin n_err++; $display("FAIL drain_data_hold: got %h want beef", bus_rr.out_data); end
    n_vec++; if (bus_rr.out_src !== 4'd2) begin n_err++; $display("FAIL drain_src_hold: got %0d want 2", bus_rr.out_src); end
  endtask

  task automatic test_rr_fairness();
    pulse_reset();
    bus_rr.req = 10'h3FF;
    bus_rr.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int exp_src;
      logic [N-1:0] exp_grant;
      exp_src   = c % N;
      exp_grant = N'(1) << exp_src;
      #1;
      n_vec++; if (bus_rr.grant !== exp_grant) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus_rr.grant, exp_grant); end
      tick();
      n_vec++; if (bus_rr.out_src !== SW'(exp_src)) begin n_err++; $display("FAIL rr_src[%0d]: got %0d want %0d", c, bus_rr.out_src, exp_src); end
      n_vec++; if (bus_rr.out_data !== words[exp_src]) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", c, bus_rr.out_data, words[exp_src]); end
      n_vec++; if (bus_rr.out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", c, bus_rr.out_valid); end
    end
    bus_rr.req = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    bus_fp.req = 10'b1000000110;
    bus_fp.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++; if (bus_fp.grant !== 10'b0000000010) begin n_err++; $display("FAIL fp_grant[%0d]: got %b want 0000000010", c, bus_fp.grant); end
      tick();
      n_vec++; if (bus_fp.out_src !== 4'd1) begin n_err++; $display("FAIL fp_src[%0d]: got %0d want 1", c, bus_fp.out_src); end
      n_vec++; if (bus_fp.out_data !== words[1]) begin n_err++; $display("FAIL fp_data[%0d]: got %h want %h", c, bus_fp.out_data, words[1]); end
    end
    bus_fp.req = 10'b1000000000;
    #1;
    n_vec++; if (bus_fp.grant !== 10'b1000000000) begin n_err++; $display("FAIL fp_top_grant: got %b want 1000000000", bus_fp.grant); end
    tick();
    n_vec++; if (bus_fp.out_src !== 4'd9) begin n_err++; $display("FAIL fp_top_src: got %0d want 9", bus_fp.out_src); end
    bus_fp.req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    words[3] = 16'h1234;
    load_words();
    bus_rr.req = 10'h3FF;
    bus_rr.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    n_vec++; if (bus_rr.out_data !== 16'h1234) begin n_err++; $display("FAIL bp_load_data: got %h want 1234", bus_rr.out_data); end
    bus_rr.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (bus_rr.grant !== 10'h000) begin n_err++; $display("FAIL bp_grant[%0d]: got %b want 0", c, bus_rr.grant); end
      tick();
      n_vec++; if (bus_rr.out_data !== 16'h1234) begin n_err++; $display("FAIL bp_data[%0d]: got %h want 1234", c, bus_rr.out_data); end
      n_vec++; if (bus_rr.out_src !== 4'd3) begin n_err++; $display("FAIL bp_src[%0d]: got %0d want 3", c, bus_rr.out_src); end
      n_vec++; if (bus_rr.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, bus_rr.out_valid); end
    end
`ifdef BUS_ARB_STALL_CNT_EN
    n_vec++; if (stall_rr !== 16'd5) begin n_err++; $display("FAIL bp_stall_count: got %0d want 5", stall_rr); end
`endif
    bus_rr.out_ready = 1'b1;
    #1;
    n_vec++; if (bus_rr.grant !== 10'b0000010000) begin n_err++; $display("FAIL bp_release_grant: got %b want 0000010000", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_src !== 4'd4) begin n_err++; $display("FAIL bp_release_src: got %0d want 4", bus_rr.out_src); end
    n_vec++; if (bus_rr.out_data !== words[4]) begin n_err++; $display("FAIL bp_release_data: got %h want %h", bus_rr.out_data, words[4]); end
`ifdef BUS_ARB_STALL_CNT_EN
    n_vec++; if (stall_rr !== 16'd5) begin n_err++; $display("FAIL bp_stall_hold: got %0d want 5", stall_rr); end
`endif
    bus_rr.req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bus_rr.req = 10'h3FF;
    bus_rr.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    bus_rr.out_ready = 1'b0;
    tick();
    n_vec++; if (bus_rr.out_src !== 4'd5) begin n_err++; $display("FAIL mid_pre_src: got %0d want 5", bus_rr.out_src); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus_rr.grant !== 10'h000) begin n_err++; $display("FAIL mid_rst_grant: got %b want 0", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus_rr.out_valid); end
    n_vec++; if (bus_rr.out_data !== 16'h0000) begin n_err++; $display("FAIL mid_data: got %h want 0000", bus_rr.out_data); end
    n_vec++; if (bus_rr.out_src !== 4'd0) begin n_err++; $display("FAIL mid_src: got %0d want 0", bus_rr.out_src); end
`ifdef BUS_ARB_STALL_CNT_EN
    n_vec++; if (stall_rr !== 16'd0) begin n_err++; $display("FAIL mid_stall: got %0d want 0", stall_rr); end
`endif
    rst = 1'b0;
    bus_rr.out_ready = 1'b1;
    #1;
    n_vec++; if (bus_rr.grant !== 10'b0000000001) begin n_err++; $display("FAIL mid_next_grant: got %b want 0000000001", bus_rr.grant); end
    tick();
    n_vec++; if (bus_rr.out_src !== 4'd0) begin n_err++; $display("FAIL mid_next_src: got %0d want 0", bus_rr.out_src); end
    bus_rr.req = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_source();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
